// File: rtl/regfile_multiport_sb.sv
// Multiported register file: three combinational reads, two prioritised writes,
// optional write-to-read bypass, hardwired zero register and a busy scoreboard.
module regfile_multiport_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addressRD,
    input  logic [ADDR_WIDTH-1:0] addressRS,
    input  logic [ADDR_WIDTH-1:0] addressRT,
    output logic [DATA_WIDTH-1:0] readRD,
    output logic [DATA_WIDTH-1:0] readRS,
    output logic [DATA_WIDTH-1:0] readRT,
    output logic                  busyRD,
    output logic                  busyRS,
    output logic                  busyRT,
    input  logic                  writeEnA,
    input  logic [ADDR_WIDTH-1:0] writeAddrA,
    input  logic [DATA_WIDTH-1:0] writeDataA,
    input  logic                  writeEnB,
    input  logic [ADDR_WIDTH-1:0] writeAddrB,
    input  logic [DATA_WIDTH-1:0] writeDataB,
    input  logic                  reserveEn,
    input  logic [ADDR_WIDTH-1:0] reserveAddr,
    output logic                  reserveConflict,
    output logic [ADDR_WIDTH:0]   busyCount
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned NPORTS    = 3;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busyNext;
    logic [CNT_WIDTH-1:0]  countNext;
    logic                  conflictNext;
    logic                  wrA;
    logic                  wrB;
    logic                  rsv;
    logic                  rsvCleared;

    logic [ADDR_WIDTH-1:0] rAddr [NPORTS];
    logic [DATA_WIDTH-1:0] rData [NPORTS];
    logic                  rBusy [NPORTS];

    // Register 0 is read-only when the zero register is enabled.
    function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    // Reset gates every same-cycle effect so reads and bypass see a cleared file.
    assign wrA = !reset && writeEnA  && writable(writeAddrA);
    assign wrB = !reset && writeEnB  && writable(writeAddrB);
    assign rsv = !reset && reserveEn && writable(reserveAddr);

    assign rAddr[0] = addressRD;
    assign rAddr[1] = addressRS;
    assign rAddr[2] = addressRT;

    always_comb begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
            rData[p] = regs[rAddr[p]];
            rBusy[p] = busy[rAddr[p]];
            if (BYPASS != 0) begin
                if (wrB && writeAddrB == rAddr[p]) begin
                    rData[p] = writeDataB;
                end else if (wrA && writeAddrA == rAddr[p]) begin
                    rData[p] = writeDataA;
                end
                // A retiring write hides busy unless a newer reserve lands on it too.
                if (((wrA && writeAddrA == rAddr[p]) || (wrB && writeAddrB == rAddr[p]))
                    && !(rsv && reserveAddr == rAddr[p])) begin
                    rBusy[p] = 1'b0;
                end
            end
            if (!writable(rAddr[p])) begin
                rData[p] = '0;
                rBusy[p] = 1'b0;
            end
        end
    end

    assign readRD = rData[0];
    assign readRS = rData[1];
    assign readRT = rData[2];
    assign busyRD = rBusy[0];
    assign busyRS = rBusy[1];
    assign busyRT = rBusy[2];

    // Writes clear first, then a reserve sets, so the newer producer wins.
    always_comb begin
        busyNext = busy;
        if (wrA) busyNext[writeAddrA] = 1'b0;
        if (wrB) busyNext[writeAddrB] = 1'b0;
        if (rsv) busyNext[reserveAddr] = 1'b1;
        countNext = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            countNext = countNext + CNT_WIDTH'(busyNext[i]);
        end
    end

    assign rsvCleared   = (wrA && writeAddrA == reserveAddr) || (wrB && writeAddrB == reserveAddr);
    assign conflictNext = rsv && busy[reserveAddr] && !rsvCleared;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wrA) regs[writeAddrA] <= writeDataA;
            if (wrB) regs[writeAddrB] <= writeDataB;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy            <= '0;
            busyCount       <= '0;
            reserveConflict <= 1'b0;
        end else begin
            busy            <= busyNext;
            busyCount       <= countNext;
            reserveConflict <= conflictNext;
        end
    end

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Bench for regfile_multiport_sb: directed vector table, hand sequences for reset
// and fill, then random traffic against an array/scoreboard reference model.
module tb_regfile_multiport_sb;

    localparam int N = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  addressRD, addressRS, addressRT;
    logic        writeEnA, writeEnB, reserveEn;
    logic [4:0]  writeAddrA, writeAddrB, reserveAddr;
    logic [31:0] writeDataA, writeDataB;

    logic [31:0] readRD1, readRS1, readRT1, readRD0, readRS0, readRT0;
    logic        busyRD1, busyRS1, busyRT1, busyRD0, busyRS0, busyRT0;
    logic        conf1, conf0;
    logic [5:0]  cnt1, cnt0;

    int nCmp = 0;
    int nFail = 0;

    always #5 clock = ~clock;

    regfile_multiport_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .ZERO_REG(1)) u1 (
        .clock(clock), .reset(reset),
        .addressRD(addressRD), .addressRS(addressRS), .addressRT(addressRT),
        .readRD(readRD1), .readRS(readRS1), .readRT(readRT1),
        .busyRD(busyRD1), .busyRS(busyRS1), .busyRT(busyRT1),
        .writeEnA(writeEnA), .writeAddrA(writeAddrA), .writeDataA(writeDataA),
        .writeEnB(writeEnB), .writeAddrB(writeAddrB), .writeDataB(writeDataB),
        .reserveEn(reserveEn), .reserveAddr(reserveAddr),
        .reserveConflict(conf1), .busyCount(cnt1));

    regfile_multiport_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .ZERO_REG(1)) u0 (
        .clock(clock), .reset(reset),
        .addressRD(addressRD), .addressRS(addressRS), .addressRT(addressRT),
        .readRD(readRD0), .readRS(readRS0), .readRT(readRT0),
        .busyRD(busyRD0), .busyRS(busyRS0), .busyRT(busyRT0),
        .writeEnA(writeEnA), .writeAddrA(writeAddrA), .writeDataA(writeDataA),
        .writeEnB(writeEnB), .writeAddrB(writeAddrB), .writeDataB(writeDataB),
        .reserveEn(reserveEn), .reserveAddr(reserveAddr),
        .reserveConflict(conf0), .busyCount(cnt0));

    // Reference model: register contents, busy flags, registered outputs.
    logic [31:0] mem [N];
    bit          busyM [N];
    int          cntM;
    bit          confM;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mem[i]   = '0;
            busyM[i] = 1'b0;
        end
        cntM  = 0;
        confM = 1'b0;
    endtask

    task automatic modelUpdate();
        int a = int'(writeAddrA);
        int b = int'(writeAddrB);
        int r = int'(reserveAddr);
        bit rsvOk = reserveEn && r != 0;
        confM = rsvOk && busyM[r] && !(writeEnA && a == r) && !(writeEnB && b == r);
        if (writeEnA && a != 0) begin mem[a] = writeDataA; busyM[a] = 1'b0; end
        if (writeEnB && b != 0) begin mem[b] = writeDataB; busyM[b] = 1'b0; end
        if (rsvOk) busyM[r] = 1'b1;
        cntM = 0;
        for (int i = 0; i < N; i++) cntM += int'(busyM[i]);
    endtask

    function automatic logic [31:0] expRead(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && writeEnB && writeAddrB == a) return writeDataB;
        if (byp && writeEnA && writeAddrA == a) return writeDataA;
        return mem[int'(a)];
    endfunction

    function automatic bit expBusy(input logic [4:0] a, input bit byp);
        bit written = (writeEnA && writeAddrA == a) || (writeEnB && writeAddrB == a);
        if (a == 5'd0) return 1'b0;
        if (byp && written && !(reserveEn && reserveAddr == a)) return 1'b0;
        return busyM[int'(a)];
    endfunction

    task automatic step();
        @(posedge clock);
        if (reset) modelReset(); else modelUpdate();
        #1;
    endtask

    task automatic idle();
        writeEnA = 1'b0; writeEnB = 1'b0; reserveEn = 1'b0;
        writeAddrA = '0; writeAddrB = '0; reserveAddr = '0;
        writeDataA = '0; writeDataB = '0;
    endtask

    typedef struct {
        bit weA; logic [4:0] aA; logic [31:0] dA;
        bit weB; logic [4:0] aB; logic [31:0] dB;
        bit rsv; logic [4:0] ra;
        logic [4:0] aRS; logic [4:0] aRT;
        logic [31:0] expRS1; logic [31:0] expRS0;
        bit expBusyRS; bit expBusyRT;
        int expCnt; bit expConf;
    } vec_t;

    function automatic vec_t mk(input bit weA, input int aA, input logic [31:0] dA,
                                input bit weB, input int aB, input logic [31:0] dB,
                                input bit rsv, input int ra, input int aRS, input int aRT,
                                input logic [31:0] e1, input logic [31:0] e0,
                                input bit bS, input bit bT, input int cnt, input bit conf);
        vec_t v;
        v.weA = weA; v.aA = 5'(aA); v.dA = dA;
        v.weB = weB; v.aB = 5'(aB); v.dB = dB;
        v.rsv = rsv; v.ra = 5'(ra);
        v.aRS = 5'(aRS); v.aRT = 5'(aRT);
        v.expRS1 = e1; v.expRS0 = e0;
        v.expBusyRS = bS; v.expBusyRT = bT;
        v.expCnt = cnt; v.expConf = conf;
        return v;
    endfunction

    vec_t vecs [11];

    initial begin
        // Dual-write collision, zero register, scoreboard flow, reserve+write on busy r9.
        vecs[0]  = mk(1'b1, 5, 32'h1111_1111, 1'b1, 5, 32'h2222_2222, 1'b0, 0, 5, 5, 32'h2222_2222, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        vecs[1]  = mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 5, 5, 32'h2222_2222, 32'h2222_2222, 1'b0, 1'b0, 0, 1'b0);
        vecs[2]  = mk(1'b1, 0, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 1'b1, 0, 0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        vecs[3]  = mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 3, 3, 3, 32'h0, 32'h0, 1'b0, 1'b0, 1, 1'b0);
        vecs[4]  = mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 7, 7, 3, 32'h0, 32'h0, 1'b0, 1'b1, 2, 1'b0);
        vecs[5]  = mk(1'b1, 3, 32'hAAAA_0003, 1'b0, 0, 32'h0, 1'b0, 0, 3, 7, 32'hAAAA_0003, 32'h0, 1'b0, 1'b1, 1, 1'b0);
        vecs[6]  = mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 7, 3, 7, 32'hAAAA_0003, 32'hAAAA_0003, 1'b0, 1'b1, 1, 1'b1);
        vecs[7]  = mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 7, 7, 32'h0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        vecs[8]  = mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 9, 9, 9, 32'h0, 32'h0, 1'b0, 1'b0, 2, 1'b0);
        vecs[9]  = mk(1'b0, 0, 32'h0, 1'b1, 9, 32'h9999_0009, 1'b1, 9, 9, 9, 32'h9999_0009, 32'h0, 1'b1, 1'b1, 2, 1'b0);
        vecs[10] = mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 9, 9, 32'h9999_0009, 32'h9999_0009, 1'b1, 1'b1, 2, 1'b0);

        reset = 1'b1;
        idle();
        addressRD = '0; addressRS = '0; addressRT = '0;
        modelReset();

        // Every address reads zero and idle while reset is held.
        for (int a = 0; a < N; a++) begin
            addressRD = 5'(a); addressRS = 5'(a); addressRT = 5'(a);
            #1;
            check($sformatf("reset readRD r%0d", a), 64'(readRD1), 64'd0);
            check($sformatf("reset readRT nobyp r%0d", a), 64'(readRT0), 64'd0);
            check($sformatf("reset busyRS r%0d", a), 64'(busyRS1), 64'd0);
        end
        check("reset busyCount", 64'(cnt1), 64'd0);
        check("reset reserveConflict", 64'(conf1), 64'd0);
        step();
        reset = 1'b0;

        foreach (vecs[i]) begin
            writeEnA = vecs[i].weA; writeAddrA = vecs[i].aA; writeDataA = vecs[i].dA;
            writeEnB = vecs[i].weB; writeAddrB = vecs[i].aB; writeDataB = vecs[i].dB;
            reserveEn = vecs[i].rsv; reserveAddr = vecs[i].ra;
            addressRS = vecs[i].aRS; addressRT = vecs[i].aRT; addressRD = vecs[i].aRS;
            #2;
            check($sformatf("vec%0d readRS bypass", i), 64'(readRS1), 64'(vecs[i].expRS1));
            check($sformatf("vec%0d readRS nobypass", i), 64'(readRS0), 64'(vecs[i].expRS0));
            check($sformatf("vec%0d readRD bypass", i), 64'(readRD1), 64'(vecs[i].expRS1));
            check($sformatf("vec%0d busyRS", i), 64'(busyRS1), 64'(vecs[i].expBusyRS));
            check($sformatf("vec%0d busyRT", i), 64'(busyRT1), 64'(vecs[i].expBusyRT));
            step();
            check($sformatf("vec%0d busyCount", i), 64'(cnt1), 64'(vecs[i].expCnt));
            check($sformatf("vec%0d reserveConflict", i), 64'(conf1), 64'(vecs[i].expConf));
        end

        // Asynchronous reset mid-cycle with a write pending: clears at once, write dropped.
        idle();
        writeEnA = 1'b1; writeAddrA = 5'd9; writeDataA = 32'h5A5A_5A5A;
        addressRS = 5'd9;
        #1;
        reset = 1'b1;
        #1;
        check("midreset readRS", 64'(readRS1), 64'd0);
        check("midreset busyRS", 64'(busyRS1), 64'd0);
        check("midreset busyCount", 64'(cnt1), 64'd0);
        step();
        idle();
        reset = 1'b0;
        #1;
        check("postreset readRS nobypass", 64'(readRS0), 64'd0);

        // Fill the scoreboard, then retire r4 from both ports at once.
        for (int r = 1; r < N; r++) begin
            reserveEn = 1'b1; reserveAddr = 5'(r);
            step();
        end
        check("fill busyCount", 64'(cnt1), 64'd31);
        check("fill reserveConflict", 64'(conf1), 64'd0);
        idle();
        writeEnA = 1'b1; writeAddrA = 5'd4; writeDataA = 32'h4444_0004;
        writeEnB = 1'b1; writeAddrB = 5'd4; writeDataB = 32'h4444_BBBB;
        addressRS = 5'd4;
        #2;
        check("dualclear readRS bypass", 64'(readRS1), 64'h4444_BBBB);
        check("dualclear busyRS", 64'(busyRS1), 64'd0);
        step();
        check("dualclear busyCount", 64'(cnt1), 64'd30);
        idle();
        #1;
        check("dualclear readRS nobypass", 64'(readRS0), 64'h4444_BBBB);
        reserveEn = 1'b1; reserveAddr = 5'd5;
        step();
        check("busy reserve conflict", 64'(conf1), 64'd1);
        check("busy reserve count", 64'(cnt1), 64'd30);
        reserveAddr = 5'd4;
        step();
        check("refill conflict", 64'(conf1), 64'd0);
        check("refill busyCount", 64'(cnt1), 64'd31);

        // Random traffic against the reference model.
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic [4:0] hi;
            hi = (c % 3 == 0) ? 5'd31 : 5'd7;
            writeEnA    = ($urandom_range(0, 2) == 0);
            writeEnB    = ($urandom_range(0, 2) == 0);
            reserveEn   = ($urandom_range(0, 1) == 0);
            writeAddrA  = 5'($urandom_range(0, int'(hi)));
            writeAddrB  = 5'($urandom_range(0, int'(hi)));
            reserveAddr = 5'($urandom_range(0, int'(hi)));
            writeDataA  = $urandom;
            writeDataB  = $urandom;
            addressRD   = 5'($urandom_range(0, int'(hi)));
            addressRS   = ($urandom_range(0, 1) == 0) ? writeAddrB : 5'($urandom_range(0, int'(hi)));
            addressRT   = ($urandom_range(0, 1) == 0) ? reserveAddr : writeAddrA;
            #2;
            check("rand readRD byp", 64'(readRD1), 64'(expRead(addressRD, 1'b1)));
            check("rand readRS byp", 64'(readRS1), 64'(expRead(addressRS, 1'b1)));
            check("rand readRT byp", 64'(readRT1), 64'(expRead(addressRT, 1'b1)));
            check("rand readRD nobyp", 64'(readRD0), 64'(expRead(addressRD, 1'b0)));
            check("rand readRS nobyp", 64'(readRS0), 64'(expRead(addressRS, 1'b0)));
            check("rand readRT nobyp", 64'(readRT0), 64'(expRead(addressRT, 1'b0)));
            check("rand busyRD byp", 64'(busyRD1), 64'(expBusy(addressRD, 1'b1)));
            check("rand busyRS byp", 64'(busyRS1), 64'(expBusy(addressRS, 1'b1)));
            check("rand busyRT byp", 64'(busyRT1), 64'(expBusy(addressRT, 1'b1)));
            check("rand busyRT nobyp", 64'(busyRT0), 64'(expBusy(addressRT, 1'b0)));
            step();
            check("rand busyCount", 64'(cnt1), 64'(cntM));
            check("rand busyCount nobyp", 64'(cnt0), 64'(cntM));
            check("rand reserveConflict", 64'(conf1), 64'(confM));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
